bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 113 +++++++++++
 tb/tb_bcd_countdown_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with load/start/pause control and a programmable
// prescaler between decrements; pulses done for one cycle when a countdown reaches 00.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       done,
    output logic       zero
);

    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_ones, r_tens, w_ones_nxt, w_tens_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          r_running, r_done, w_done_nxt;
    logic          w_zero, w_tick;
    logic [3:0]    w_ld_ones, w_ld_tens;

    assign w_zero    = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_tick    = (r_presc == TICK_LAST);
    assign w_ld_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
    assign w_ld_tens = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ones    <= w_ones_nxt;
            r_tens    <= w_tens_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and datapath; load overrides every state
    always_comb begin
        w_state_nxt = r_state;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_state_nxt = IDLE;
            w_ones_nxt  = w_ld_ones;
            w_tens_nxt  = w_ld_tens;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !w_zero) begin
                        w_state_nxt = RUN;
                        w_presc_nxt = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        w_state_nxt = PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        // BCD borrow; the 01 -> 00 step ends the countdown
                        if (r_ones != 4'd0) begin
                            w_ones_nxt = r_ones - 4'd1;
                            if ((r_ones == 4'd1) && (r_tens == 4'd0)) begin
                                w_state_nxt = IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else if (r_tens != 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign ones    = r_ones;
    assign tens    = r_tens;
    assign running = r_running;
    assign done    = r_done;
    assign zero    = w_zero;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer; a TICK_DIV=1 and a TICK_DIV=4
// instance share the stimulus and each is checked in its own scenarios.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] ones1, tens1, ones4, tens4;
    logic       running1, done1, zero1, running4, done4, zero4;

    int checks = 0;
    int errors = 0;
    int dones  = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .ones(ones1), .tens(tens1),
        .running(running1), .done(done1), .zero(zero1)
    );

    bcd_countdown_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .ones(ones4), .tens(tens4),
        .running(running4), .done(done4), .zero(zero4)
    );

    function automatic logic [7:0] bcd(input int k);
        return {4'(k / 10), 4'(k % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int cnt, input logic run, input logic dn);
        chk({tag, "_digits"}, {tens1, ones1}, bcd(cnt));
        chk({tag, "_running"}, 8'(running1), 8'(run));
        chk({tag, "_done"}, 8'(done1), 8'(dn));
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
        #12;
        chk1("reset", 0, 1'b0, 1'b0);
        chk("reset_zero", 8'(zero1), 8'd1);
        step();
        rst = 1'b1;
        step();

        // Full countdown from 25 with borrow at 20 -> 19
        load = 1'b1; load_val = 8'h25;
        step();
        load = 1'b0;
        chk1("load25", 25, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("start25", 25, 1'b1, 1'b0);
        for (int k = 24; k >= 0; k--) begin
            step();
            chk1($sformatf("cnt25_%0d", k), k, (k != 0), (k == 0));
        end
        step();
        chk1("after25", 0, 1'b0, 1'b0);
        chk("after25_zero", 8'(zero1), 8'd1);

        // Pause at 07, hold, resume to 00
        load = 1'b1; load_val = 8'h10;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 9; k >= 7; k--) step();
        chk1("pre_pause", 7, 1'b1, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1($sformatf("paused_%0d", i), 7, 1'b0, 1'b0);
        end
        pause = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk1("resume", 7, 1'b1, 1'b0);
        dones = 0;
        for (int k = 6; k >= 0; k--) begin
            step();
            if (done1) dones++;
            chk({"resume_cnt"}, {tens1, ones1}, bcd(k));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (done1) dones++;
        end
        chk("resume_done_count", 8'(dones), 8'd1);
        chk1("resume_end", 0, 1'b0, 1'b0);

        // Clamping and ignored start at 00
        load = 1'b1; load_val = 8'hAF;
        step();
        chk1("clamp_AF", 99, 1'b0, 1'b0);
        load_val = 8'h3C;
        step();
        chk1("clamp_3C", 39, 1'b0, 1'b0);
        load_val = 8'hA2;
        step();
        chk1("clamp_A2", 92, 1'b0, 1'b0);
        load_val = 8'h00;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk1("start00", 0, 1'b0, 1'b0);
        chk("start00_zero", 8'(zero1), 8'd1);
        step();
        chk1("start00_b", 0, 1'b0, 1'b0);

        // Load during RUN, then start+pause priority
        load = 1'b1; load_val = 8'h20;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 19; k >= 15; k--) step();
        chk1("at15", 15, 1'b1, 1'b0);
        load = 1'b1; load_val = 8'h42; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        chk1("load_in_run", 42, 1'b0, 1'b0);
        step();
        chk1("load_in_run_b", 42, 1'b0, 1'b0);
        start = 1'b1;
        step();
        chk1("run42", 42, 1'b1, 1'b0);
        pause = 1'b1;
        step();
        chk1("pause_wins_run", 42, 1'b0, 1'b0);
        step();
        chk1("pause_start_hold", 42, 1'b0, 1'b0);
        pause = 1'b0;
        step();
        start = 1'b0;
        chk1("resume42", 42, 1'b1, 1'b0);
        step();
        chk1("dec41", 41, 1'b1, 1'b0);

        // Asynchronous reset mid-countdown
        load = 1'b1; load_val = 8'h10;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk1("at08", 8, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk1("async_rst", 0, 1'b0, 1'b0);
        chk("async_rst_zero", 8'(zero1), 8'd1);
        step();
        rst = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("post_rst_start", 0, 1'b0, 1'b0);
        step();
        chk1("post_rst_idle", 0, 1'b0, 1'b0);

        // TICK_DIV=4: one decrement every 4th RUN cycle
        load = 1'b1; load_val = 8'h03;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("div4_start_run", 8'(running4), 8'd1);
        chk("div4_start_digits", {tens4, ones4}, 8'h03);
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done4) dones++;
            chk($sformatf("div4_digits_%0d", i), {tens4, ones4}, bcd(3 - i / 4));
            chk($sformatf("div4_running_%0d", i), 8'(running4), 8'((i < 12) ? 1 : 0));
            chk($sformatf("div4_done_%0d", i), 8'(done4), 8'((i == 12) ? 1 : 0));
        end
        step();
        if (done4) dones++;
        chk("div4_done_count", 8'(dones), 8'd1);
        chk("div4_zero", 8'(zero4), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
